dma_channel_arbiter: RTL and testbench
======================================

Name: dma_channel_arbiter

Overview:
- Request/priority stage directly upstream of the DMA timing-control FSM.
- Qualifies the four channel requests: sense polarity, mask register, software request register, controller disable.
- Selects one channel by fixed or rotating priority and presents it to the timing FSM as a one-hot valid request.
- Drives DACK for the selected channel during service and updates rotating priority when service completes.

Parameters:
- NUM_CH, 4, number of DMA channels. Only 4 is supported; the grant encoding is 2 bits.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- DREQ  in  4  raw peripheral requests
- cmd_dreq_sense  in  1  command bit 6: 0 = DREQ active-high, 1 = active-low
- cmd_dack_sense  in  1  command bit 7: 0 = DACK active-low, 1 = active-high
- cmd_rotating  in  1  command bit 4: 1 = rotating priority
- cmd_disable  in  1  command bit 2: controller disable
- mask_reg  in  4  per-channel mask; 1 = masked
- req_wr  in  1  one-cycle strobe, request-register write
- req_data  in  3  [2] 1 = set / 0 = clear, [1:0] channel
- svc_start  in  1  timing FSM entered S1 (validDACK)
- svc_done  in  1  timing FSM in S4, end of service
- tc  in  1  terminal count of the serviced channel, qualified with svc_done
- valid_dreq  out  4  one-hot request to the timing FSM
- grant_ch  out  2  encoded selected channel
- busy  out  1  high in the REQ or SVC state
- DACK  out  4  acknowledge, polarity set by cmd_dack_sense
- request_reg  out  4  software request bits, feeds status bits [7:4]

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE; valid_dreq=0; grant_ch=0; busy=0.
  - Internal dack=0, so DACK = all inactive at the current cmd_dack_sense level.
  - sreq=0; prio_ptr=0; dreq_q=0.
- Request qualification:
  - dreq_q registers DREQ XOR {4{cmd_dreq_sense}} each cycle (1-cycle latency).
  - eff_req = (dreq_q & ~mask_reg) | sreq. Software requests ignore the mask.
- Priority:
  - Fixed mode (cmd_rotating=0): ch0 highest, ch3 lowest. prio_ptr is held at 0 while cmd_rotating=0.
  - Rotating mode: prio_ptr is the highest-priority channel; order is ptr, ptr+1, ... mod 4.
- State IDLE:
  - If !cmd_disable and eff_req != 0, register the winner into grant_ch, set valid_dreq = one-hot(winner), go to REQ.
  - Otherwise stay in IDLE.
- State REQ:
  - Grant is frozen; a later higher-priority request does not preempt.
  - svc_start: go to SVC, set dack[grant_ch]=1 on the same edge.
  - eff_req[grant_ch]=0 (request withdrawn) or cmd_disable=1 before svc_start: clear valid_dreq, go to IDLE.
  - If svc_start and withdrawal occur in the same cycle, svc_start wins.
- State SVC:
  - valid_dreq and dack stay held. Request withdrawal and cmd_disable are ignored; service always completes.
  - svc_done: clear dack and valid_dreq, go to IDLE.
  - On svc_done, if cmd_rotating, prio_ptr = grant_ch+1 mod 4, so the serviced channel becomes lowest priority.
  - On svc_done with tc=1, clear sreq[grant_ch].
  - Minimum re-arbitration gap: one cycle in IDLE after svc_done.
- Request register:
  - On req_wr, sreq[req_data[1:0]] = req_data[2].
  - If req_wr and a tc-clear hit the same channel in the same cycle, the write wins.
  - request_reg = sreq.
- Output rules:
  - DACK = cmd_dack_sense ? dack : ~dack.
  - busy = (state != IDLE).
  - At most one valid_dreq bit and one dack bit is ever set.
- Unexpected strobes: svc_start outside REQ and svc_done outside SVC are ignored.

Decomposition:
- Package dma_arb_pkg:
  - NUM_CH constant.
  - arb_state_t enum {IDLE, REQ, SVC}.
  - Function onehot4(logic [1:0]).
- Sub-module dma_prio_encoder: combinational.
  - Inputs: eff_req[3:0], prio_ptr[1:0].
  - Outputs: winner[1:0], any.
  - Implemented as rotate-right, fixed encode, add back.

Test Plan:
- Fixed priority: DREQ=4'b1010, senses 0, mask 0 → after 2 cycles valid_dreq=4'b0010, grant_ch=1. svc_start → DACK=4'b1101. svc_done → DACK=4'b1111, next grant ch3.
- Rotating: cmd_rotating=1, ch0 serviced, then DREQ=4'b0101 → grant ch2, prio_ptr=1. After ch2 done, prio_ptr=3.
- Mask and software request: mask_reg=4'b1111, DREQ=4'b1111 → no grant. req_wr with req_data=3'b110 → grant ch2, request_reg=4'b0100. svc_done with tc=1 → request_reg=0.
- Withdrawal: DREQ[0] rises, then falls while in REQ → valid_dreq returns to 0, DACK never asserts, state IDLE.
- Polarity: cmd_dreq_sense=1, cmd_dack_sense=1, DREQ=4'b1110 → grant ch0. svc_start → DACK=4'b0001.
- Reset mid-SVC: RESET_N low while DACK[1] is active → asynchronously DACK inactive, valid_dreq=0, busy=0, request_reg=0.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA request/priority stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_arb_pkg;

   // Channel count; the grant encoding is fixed at 2 bits, so only 4 works.
   localparam int NUM_CH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SVC  = 2'd2
   } arb_state_t;

   function automatic logic [3:0] onehot4(input logic [1:0] ch);
      onehot4 = 4'b0001 << ch;
   endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Picks one channel from eff_req, with prio_ptr naming the highest-priority channel.
// Latency: combinational.
// Backpressure: none.
// Ports: eff_req (qualified requests), prio_ptr (top-priority channel),
//        winner (selected channel), any (at least one request present).
module dma_prio_encoder (
   input  logic [3:0] eff_req,
   input  logic [1:0] prio_ptr,
   output logic [1:0] winner,
   output logic       any
);

   logic [3:0] rot;
   logic [1:0] enc;

   // Rotate right by prio_ptr so the top-priority channel lands on bit 0.
   always_comb begin
      case (prio_ptr)
         2'd0:    rot = eff_req;
         2'd1:    rot = {eff_req[0],   eff_req[3:1]};
         2'd2:    rot = {eff_req[1:0], eff_req[3:2]};
         default: rot = {eff_req[2:0], eff_req[3]};
      endcase
   end

   // Fixed encode: lowest set bit wins.
   always_comb begin
      casez (rot)
         4'b???1: enc = 2'd0;
         4'b??10: enc = 2'd1;
         4'b?100: enc = 2'd2;
         4'b1000: enc = 2'd3;
         default: enc = 2'd0;
      endcase
   end

   // Undo the rotation; 2-bit add wraps mod 4.
   assign winner = enc + prio_ptr;
   assign any    = |eff_req;

endmodule

// File: rtl/dma_channel_arbiter.sv
// Qualifies four DMA channel requests and grants one to the timing FSM; drives DACK during service.
// Latency: DREQ to valid_dreq is 2 cycles (sense register, then arbitration register).
// Backpressure: a grant is held in REQ until svc_start or withdrawal; service always runs to svc_done.
// Ports: CLK/RESET_N; DREQ raw requests; cmd_* command bits; mask_reg; req_wr/req_data software
//        request writes; svc_start/svc_done/tc from the timing FSM; valid_dreq/grant_ch/busy to the
//        timing FSM; DACK to the peripherals; request_reg to the status register.
module dma_channel_arbiter
   import dma_arb_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [3:0] DREQ,
   input  logic       cmd_dreq_sense,
   input  logic       cmd_dack_sense,
   input  logic       cmd_rotating,
   input  logic       cmd_disable,
   input  logic [3:0] mask_reg,
   input  logic       req_wr,
   input  logic [2:0] req_data,
   input  logic       svc_start,
   input  logic       svc_done,
   input  logic       tc,
   output logic [3:0] valid_dreq,
   output logic [1:0] grant_ch,
   output logic       busy,
   output logic [3:0] DACK,
   output logic [3:0] request_reg
);

   arb_state_t state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [3:0] vld_q, vld_d;
   logic [3:0] dack_q, dack_d;
   logic [3:0] sreq_q, sreq_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] dreq_q;

   logic [3:0] eff_req;
   logic [1:0] winner;
   logic       any;

   // Software requests bypass the mask.
   assign eff_req = (dreq_q & ~mask_reg) | sreq_q;

   dma_prio_encoder u_prio (
      .eff_req  (eff_req),
      .prio_ptr (ptr_q),
      .winner   (winner),
      .any      (any)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      vld_d   = vld_q;
      dack_d  = dack_q;
      ptr_d   = ptr_q;
      sreq_d  = sreq_q;
      case (state_q)
         IDLE: begin
            if (!cmd_disable && any) begin
               grant_d = winner;
               vld_d   = onehot4(winner);
               state_d = REQ;
            end
         end
         REQ: begin
            // svc_start takes precedence over a same-cycle withdrawal.
            if (svc_start) begin
               dack_d  = onehot4(grant_q);
               state_d = SVC;
            end else if (!eff_req[grant_q] || cmd_disable) begin
               vld_d   = '0;
               state_d = IDLE;
            end
         end
         SVC: begin
            if (svc_done) begin
               vld_d   = '0;
               dack_d  = '0;
               state_d = IDLE;
               // Serviced channel drops to lowest priority.
               if (cmd_rotating) ptr_d = grant_q + 2'd1;
               if (tc)           sreq_d[grant_q] = 1'b0;
            end
         end
         default: begin
            vld_d   = '0;
            dack_d  = '0;
            state_d = IDLE;
         end
      endcase
      if (!cmd_rotating) ptr_d = '0;
      // A register write overrides a same-cycle terminal-count clear.
      if (req_wr) sreq_d[req_data[1:0]] = req_data[2];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         grant_q <= '0;
         vld_q   <= '0;
         dack_q  <= '0;
         sreq_q  <= '0;
         ptr_q   <= '0;
         dreq_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         vld_q   <= vld_d;
         dack_q  <= dack_d;
         sreq_q  <= sreq_d;
         ptr_q   <= ptr_d;
         dreq_q  <= DREQ ^ {4{cmd_dreq_sense}};
      end
   end

   assign valid_dreq  = vld_q;
   assign grant_ch    = grant_q;
   assign busy        = (state_q != IDLE);
   assign DACK        = cmd_dack_sense ? dack_q : ~dack_q;
   assign request_reg = sreq_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
module tb_dma_channel_arbiter;

   logic       CLK;
   logic       RESET_N;
   logic [3:0] DREQ;
   logic       cmd_dreq_sense, cmd_dack_sense, cmd_rotating, cmd_disable;
   logic [3:0] mask_reg;
   logic       req_wr;
   logic [2:0] req_data;
   logic       svc_start, svc_done, tc;
   logic [3:0] valid_dreq;
   logic [1:0] grant_ch;
   logic       busy;
   logic [3:0] DACK;
   logic [3:0] request_reg;

   int errors = 0;
   int checks = 0;

   // Reference model: 0 = idle, 1 = request presented, 2 = in service.
   int         m_state;
   int         m_grant;
   int         m_ptr;
   logic [3:0] m_dq;
   logic [3:0] m_sreq;

   dma_channel_arbiter dut (
      .CLK            (CLK),
      .RESET_N        (RESET_N),
      .DREQ           (DREQ),
      .cmd_dreq_sense (cmd_dreq_sense),
      .cmd_dack_sense (cmd_dack_sense),
      .cmd_rotating   (cmd_rotating),
      .cmd_disable    (cmd_disable),
      .mask_reg       (mask_reg),
      .req_wr         (req_wr),
      .req_data       (req_data),
      .svc_start      (svc_start),
      .svc_done       (svc_done),
      .tc             (tc),
      .valid_dreq     (valid_dreq),
      .grant_ch       (grant_ch),
      .busy           (busy),
      .DACK           (DACK),
      .request_reg    (request_reg)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [3:0] oh(input int ch);
      logic [3:0] r;
      r = 4'b0;
      r[ch] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_grant = 0;
      m_ptr   = 0;
      m_dq    = 4'b0;
      m_sreq  = 4'b0;
   endtask

   task automatic compare(input string tag);
      logic [3:0] ev, ed;
      ev = (m_state != 0) ? oh(m_grant) : 4'b0;
      ed = (m_state == 2) ? oh(m_grant) : 4'b0;
      if (!cmd_dack_sense) ed = ~ed;
      chk({tag, ".valid_dreq"}, valid_dreq, ev);
      chk({tag, ".grant_ch"}, {2'b00, grant_ch}, 4'(m_grant));
      chk({tag, ".busy"}, {3'b000, busy}, {3'b000, (m_state != 0)});
      chk({tag, ".DACK"}, DACK, ed);
      chk({tag, ".request_reg"}, request_reg, m_sreq);
   endtask

   // Advance the model by one clock using the present inputs, clock the DUT, then compare.
   task automatic step(input string tag);
      logic [3:0] eff, nsr;
      int ns, ng, np;
      eff = (m_dq & ~mask_reg) | m_sreq;
      ns = m_state; ng = m_grant; np = m_ptr; nsr = m_sreq;
      if (m_state == 0) begin
         if (!cmd_disable && eff != 4'b0) begin
            // Walk priority order from lowest to highest; the last hit is the winner.
            for (int k = 3; k >= 0; k--)
               if (eff[(m_ptr + k) % 4]) ng = (m_ptr + k) % 4;
            ns = 1;
         end
      end else if (m_state == 1) begin
         if (svc_start) ns = 2;
         else if (!eff[m_grant] || cmd_disable) ns = 0;
      end else begin
         if (svc_done) begin
            ns = 0;
            if (cmd_rotating) np = (m_grant + 1) % 4;
            if (tc) nsr[m_grant] = 1'b0;
         end
      end
      if (!cmd_rotating) np = 0;
      if (req_wr) nsr[req_data[1:0]] = req_data[2];
      m_state = ns; m_grant = ng; m_ptr = np; m_sreq = nsr;
      m_dq = DREQ ^ {4{cmd_dreq_sense}};
      @(posedge CLK);
      #1;
      compare(tag);
   endtask

   initial begin
      RESET_N = 1'b0;
      DREQ = 4'b0; mask_reg = 4'b0;
      cmd_dreq_sense = 1'b0; cmd_dack_sense = 1'b0; cmd_rotating = 1'b0; cmd_disable = 1'b0;
      req_wr = 1'b0; req_data = 3'b0; svc_start = 1'b0; svc_done = 1'b0; tc = 1'b0;
      model_reset();
      #12;
      compare("reset");
      chk("reset.DACK_inactive", DACK, 4'b1111);
      RESET_N = 1'b1;

      // Fixed priority
      DREQ = 4'b1010;
      step("fx1"); step("fx2");
      chk("fx.vld", valid_dreq, 4'b0010);
      chk("fx.gnt", {2'b00, grant_ch}, 4'd1);
      svc_start = 1'b1; step("fx_start"); svc_start = 1'b0;
      chk("fx.dack_on", DACK, 4'b1101);
      svc_done = 1'b1; DREQ = 4'b1000; step("fx_done"); svc_done = 1'b0;
      chk("fx.dack_off", DACK, 4'b1111);
      chk("fx.gap_idle", {3'b000, busy}, 4'b0000);
      step("fx_next");
      chk("fx.next_gnt", {2'b00, grant_ch}, 4'd3);
      svc_start = 1'b1; step("fx3_start"); svc_start = 1'b0;
      svc_done = 1'b1; DREQ = 4'b0; step("fx3_done"); svc_done = 1'b0;
      step("fx_idle");

      // Rotating priority
      cmd_rotating = 1'b1; DREQ = 4'b0001;
      step("rot1"); step("rot2");
      svc_start = 1'b1; step("rot_s0"); svc_start = 1'b0;
      svc_done = 1'b1; DREQ = 4'b0101; step("rot_d0"); svc_done = 1'b0;
      step("rot_arb2");
      chk("rot.gnt2", {2'b00, grant_ch}, 4'd2);
      svc_start = 1'b1; step("rot_s2"); svc_start = 1'b0;
      svc_done = 1'b1; DREQ = 4'b1001; step("rot_d2"); svc_done = 1'b0;
      step("rot_arb3");
      chk("rot.gnt3", {2'b00, grant_ch}, 4'd3);
      svc_start = 1'b1; step("rot_s3"); svc_start = 1'b0;
      svc_done = 1'b1; DREQ = 4'b0; step("rot_d3"); svc_done = 1'b0;
      cmd_rotating = 1'b0; step("rot_off");

      // Mask and software request
      mask_reg = 4'b1111; DREQ = 4'b1111;
      step("msk1"); step("msk2"); step("msk3");
      chk("msk.no_grant", {3'b000, busy}, 4'b0000);
      req_wr = 1'b1; req_data = 3'b110; step("sw_wr"); req_wr = 1'b0;
      chk("sw.reqreg", request_reg, 4'b0100);
      step("sw_arb");
      chk("sw.gnt", {2'b00, grant_ch}, 4'd2);
      chk("sw.vld", valid_dreq, 4'b0100);
      svc_start = 1'b1; step("sw_start"); svc_start = 1'b0;
      svc_done = 1'b1; tc = 1'b1; step("sw_done"); svc_done = 1'b0; tc = 1'b0;
      chk("sw.tc_clear", request_reg, 4'b0000);
      DREQ = 4'b0; step("msk_clr");
      mask_reg = 4'b0; step("msk_off");

      // Withdrawal in REQ
      DREQ = 4'b0001;
      step("wd1"); step("wd2");
      chk("wd.vld", valid_dreq, 4'b0001);
      DREQ = 4'b0; step("wd3");
      step("wd4");
      chk("wd.vld_clear", valid_dreq, 4'b0000);
      chk("wd.idle", {3'b000, busy}, 4'b0000);
      chk("wd.no_dack", DACK, 4'b1111);

      // Polarity
      cmd_dreq_sense = 1'b1; cmd_dack_sense = 1'b1; DREQ = 4'b1110;
      step("pol1"); step("pol2");
      chk("pol.gnt", {2'b00, grant_ch}, 4'd0);
      svc_start = 1'b1; step("pol_start"); svc_start = 1'b0;
      chk("pol.dack", DACK, 4'b0001);
      svc_done = 1'b1; DREQ = 4'b1111; step("pol_done"); svc_done = 1'b0;
      step("pol_idle");
      cmd_dreq_sense = 1'b0; cmd_dack_sense = 1'b0; DREQ = 4'b0;
      step("pol_restore");

      // Asynchronous reset during service
      DREQ = 4'b0010; req_wr = 1'b1; req_data = 3'b111;
      step("rs1"); req_wr = 1'b0;
      step("rs2");
      svc_start = 1'b1; step("rs_start"); svc_start = 1'b0;
      chk("rs.dack_on", DACK, 4'b1101);
      RESET_N = 1'b0;
      model_reset();
      #1;
      compare("rs_async");
      chk("rs.dack_off", DACK, 4'b1111);
      chk("rs.reqreg", request_reg, 4'b0000);
      DREQ = 4'b0;
      #2 RESET_N = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         DREQ      = 4'($urandom);
         svc_start = ($urandom_range(0, 2) == 0);
         svc_done  = ($urandom_range(0, 2) == 0);
         tc        = ($urandom_range(0, 1) == 0);
         req_wr    = ($urandom_range(0, 7) == 0);
         req_data  = 3'($urandom);
         cmd_disable = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) mask_reg = 4'($urandom);
         if ($urandom_range(0, 31) == 0) cmd_rotating = ~cmd_rotating;
         if ($urandom_range(0, 31) == 0) cmd_dreq_sense = ~cmd_dreq_sense;
         if ($urandom_range(0, 31) == 0) cmd_dack_sense = ~cmd_dack_sense;
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
